// File: rtl/ft245_sync_burst.sv
// Synchronous FT245-style FIFO bridge with an arbitrated RX/TX burst FSM.
// It provides OE-before-RD turnaround, round-robin fairness with a burst cap, and a SIWU# flush after TX idle.
module ft245_sync_burst #(
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 64,
  parameter int SIWU_IDLE = 16
) (
  input  logic              ft_clkout,
  input  logic              rst,
  input  logic [DATA_W-1:0] ft_bus_in,
  output logic [DATA_W-1:0] ft_bus_out,
  output logic              ft_bus_oe,
  input  logic              ft_rxf_n,
  input  logic              ft_txe_n,
  output logic              ft_oe_n,
  output logic              ft_rd_n,
  output logic              ft_wr_n,
  output logic              ft_siwu_n,
  input  logic [DATA_W-1:0] tx_rdata,
  input  logic              tx_rempty,
  output logic              tx_rinc,
  output logic [DATA_W-1:0] rx_wdata,
  input  logic              rx_wfull,
  output logic              rx_winc
);
  typedef enum logic [2:0] {IDLE, RX_OE, RX_READ, TURN, TX_WRITE} state_t;

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int SW = (SIWU_IDLE > 1) ? $clog2(SIWU_IDLE) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
  localparam logic DIR_RX = 1'b0;
  localparam logic DIR_TX = 1'b1;

  state_t          state_q, state_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic            last_dir_q, last_dir_d;
  logic [SW-1:0]   siwu_cnt_q, siwu_cnt_d;
  logic            tx_dirty_q, tx_dirty_d;
  logic            siwu_n_q, siwu_n_d;
  logic            rd_act, wr_act, rx_req, tx_req;

  // Strobes are gated by rst so a reset mid-burst releases the bus in the same cycle.
  assign rd_act     = (state_q == RX_READ) & ~rx_wfull & ~rst;
  assign wr_act     = (state_q == TX_WRITE) & ~tx_rempty & ~rst;
  assign ft_oe_n    = ~(((state_q == RX_OE) | (state_q == RX_READ)) & ~rst);
  assign ft_rd_n    = ~rd_act;
  assign ft_wr_n    = ~wr_act;
  assign ft_bus_oe  = (state_q == TX_WRITE) & ~rst;
  assign rx_winc    = rd_act & ~ft_rxf_n;
  assign tx_rinc    = wr_act & ~ft_txe_n;
  assign ft_siwu_n  = siwu_n_q | rst;
  assign rx_wdata   = ft_bus_in;
  assign ft_bus_out = tx_rdata;
  assign rx_req     = ~ft_rxf_n & ~rx_wfull;
  assign tx_req     = ~ft_txe_n & ~tx_rempty;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    last_dir_d  = last_dir_q;
    case (state_q)
      IDLE: begin
        burst_cnt_d = '0;
        // On a tie the direction not served last wins.
        if (rx_req && (!tx_req || last_dir_q == DIR_TX)) state_d = RX_OE;
        else if (tx_req)                                 state_d = TX_WRITE;
      end
      RX_OE: state_d = RX_READ;
      RX_READ: begin
        if (rx_winc) burst_cnt_d = burst_cnt_q + BW'(1);
        if (ft_rxf_n || (rx_winc && burst_cnt_q == BURST_LAST)) begin
          state_d    = TURN;
          last_dir_d = DIR_RX;
        end
      end
      TURN: state_d = IDLE;
      TX_WRITE: begin
        if (tx_rinc) burst_cnt_d = burst_cnt_q + BW'(1);
        if (tx_rempty || (tx_rinc && burst_cnt_q == BURST_LAST)) begin
          state_d    = IDLE;
          last_dir_d = DIR_TX;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  generate
    if (SIWU_IDLE > 0) begin : g_siwu
      localparam logic [SW-1:0] SIWU_LAST = SW'(SIWU_IDLE - 1);
      always_comb begin
        siwu_cnt_d = siwu_cnt_q;
        tx_dirty_d = tx_dirty_q;
        siwu_n_d   = 1'b1;
        if (tx_rinc) begin
          siwu_cnt_d = '0;
          tx_dirty_d = 1'b1;
        end else if (tx_dirty_q && tx_rempty) begin
          if (siwu_cnt_q == SIWU_LAST) begin
            siwu_n_d   = 1'b0;
            tx_dirty_d = 1'b0;
            siwu_cnt_d = '0;
          end else begin
            siwu_cnt_d = siwu_cnt_q + SW'(1);
          end
        end
      end
    end else begin : g_no_siwu
      always_comb begin
        siwu_cnt_d = '0;
        tx_dirty_d = 1'b0;
        siwu_n_d   = 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge ft_clkout) begin
    if (rst) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      last_dir_q  <= DIR_TX;
      siwu_cnt_q  <= '0;
      tx_dirty_q  <= 1'b0;
      siwu_n_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_dir_q  <= last_dir_d;
      siwu_cnt_q  <= siwu_cnt_d;
      tx_dirty_q  <= tx_dirty_d;
      siwu_n_q    <= siwu_n_d;
    end
  end
endmodule

// File: tb/tb_ft245_sync_burst.sv
// Scoreboard bench for ft245_sync_burst: an FT model and a TX FIFO model feed the DUT.
// A negedge monitor checks data order, strobe protocol, burst grants and SIWU timing.
module tb_ft245_sync_burst;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] ft_bus_in, ft_bus_out, tx_rdata, rx_wdata;
  logic          ft_bus_oe, ft_rxf_n, ft_txe_n, ft_oe_n, ft_rd_n, ft_wr_n, ft_siwu_n;
  logic          tx_rempty, tx_rinc, rx_wfull, rx_winc;

  always #5 clk = ~clk;

  ft245_sync_burst #(.DATA_W(DW), .BURST_MAX(4), .SIWU_IDLE(16)) dut (
    .ft_clkout(clk), .rst(rst), .ft_bus_in(ft_bus_in), .ft_bus_out(ft_bus_out),
    .ft_bus_oe(ft_bus_oe), .ft_rxf_n(ft_rxf_n), .ft_txe_n(ft_txe_n), .ft_oe_n(ft_oe_n),
    .ft_rd_n(ft_rd_n), .ft_wr_n(ft_wr_n), .ft_siwu_n(ft_siwu_n), .tx_rdata(tx_rdata),
    .tx_rempty(tx_rempty), .tx_rinc(tx_rinc), .rx_wdata(rx_wdata), .rx_wfull(rx_wfull),
    .rx_winc(rx_winc)
  );

  // FT source words and TX FIFO contents, consumed through pointers advanced on accepts
  logic [DW-1:0] rx_src [256];
  logic [DW-1:0] tx_fifo[256];
  int rx_src_n = 0, rx_src_p = 0, tx_n = 0, tx_p = 0;
  assign ft_rxf_n  = (rx_src_p >= rx_src_n);
  assign ft_bus_in = rx_src[rx_src_p[7:0]];
  assign tx_rempty = (tx_p >= tx_n);
  assign tx_rdata  = tx_fifo[tx_p[7:0]];

  always @(posedge clk) begin
    if (rx_winc) rx_src_p <= rx_src_p + 1;
    if (tx_rinc) tx_p <= tx_p + 1;
  end

  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] exp_rx[$], exp_tx[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor state
  int cyc = 0, rx_acc = 0, tx_acc = 0, last_tx_cyc = 0, pulses = 0, wf_stall = 0;
  bit armed = 0, prev_oe_low = 0, prev_tx_win = 0, rd_started = 0;
  int oe_lead = 0, rx_run = 0, tx_run = 0;
  int blog[64];
  int blog_n = 0;

  always @(negedge clk) begin
    cyc++;
    if (rx_winc) begin
      if (exp_rx.size() == 0) chk("rx_unexpected", {24'd0, rx_wdata}, 32'hFFFF_FFFF);
      else chk("rx_data", {24'd0, rx_wdata}, {24'd0, exp_rx.pop_front()});
      rx_acc++;
    end
    if (tx_rinc) begin
      if (exp_tx.size() == 0) chk("tx_unexpected", {24'd0, ft_bus_out}, 32'hFFFF_FFFF);
      else chk("tx_data", {24'd0, ft_bus_out}, {24'd0, exp_tx.pop_front()});
      tx_acc++;
      last_tx_cyc = cyc;
      armed = 1;
    end
    if (!ft_oe_n) begin
      if (!ft_rd_n && !rd_started) begin
        rd_started = 1;
        chk("oe_lead", oe_lead, 1);
      end else if (ft_rd_n && !rd_started) oe_lead++;
      rx_run += int'(rx_winc);
    end else if (prev_oe_low) begin
      if (blog_n < 64) blog[blog_n] = 100 + rx_run;
      blog_n++;
      chk("turn_bus_oe", {31'd0, ft_bus_oe}, 0);
      rx_run = 0; oe_lead = 0; rd_started = 0;
    end
    prev_oe_low = !ft_oe_n;
    if (ft_bus_oe) begin
      chk("bus_contention", {31'd0, ft_oe_n}, 1);
      tx_run += int'(tx_rinc);
    end else if (prev_tx_win) begin
      if (blog_n < 64) blog[blog_n] = 200 + tx_run;
      blog_n++;
      tx_run = 0;
    end
    prev_tx_win = ft_bus_oe;
    if (rx_wfull && !ft_oe_n && rd_started) begin
      chk("wfull_stall", {30'd0, ft_rd_n, rx_winc}, 2);
      wf_stall++;
    end
    if (!ft_siwu_n) begin
      chk("siwu_delay", cyc - last_tx_cyc, 17);
      chk("siwu_armed", {31'd0, armed}, 1);
      armed = 0;
      pulses++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_acc(input bit is_tx, input int target, input string nm);
    int n = 0;
    while ((is_tx ? tx_acc : rx_acc) < target && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) chk({nm, "_timeout"}, is_tx ? tx_acc : rx_acc, target);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_outs", {25'd0, ft_oe_n, ft_rd_n, ft_wr_n, ft_siwu_n, ft_bus_oe, rx_winc, tx_rinc},
          7'b1111000);
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic offer_rx(input logic [DW-1:0] w);
    rx_src[rx_src_n[7:0]] = w; rx_src_n++; exp_rx.push_back(w);
  endtask

  task automatic load_tx(input logic [DW-1:0] w);
    tx_fifo[tx_n[7:0]] = w; tx_n++; exp_tx.push_back(w);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, lb, p0;
    int exp4[6];
    rst = 1'b1; rx_wfull = 1'b0; ft_txe_n = 1'b0;
    do_reset();
    cycles(2);

    // RX A0..A4 with burst cap 4: RX4 then RX1, oe_n leads rd_n each time
    base = rx_acc; lb = blog_n;
    for (int i = 0; i < 5; i++) offer_rx(8'hA0 + 8'(i));
    wait_acc(0, base + 5, "rx_a");
    cycles(4);
    chk("rx_a_count", rx_acc - base, 5);
    chk("rx_a_burst0", blog[lb], 104);
    chk("rx_a_burst1", blog[lb + 1], 101);

    // TX 11,22,33 with txe_n high for 2 cycles after the first accept
    base = tx_acc; lb = blog_n;
    load_tx(8'h11); load_tx(8'h22); load_tx(8'h33);
    wait_acc(1, base + 1, "tx_first");
    ft_txe_n = 1'b1;
    cycles(2);
    ft_txe_n = 1'b0;
    wait_acc(1, base + 3, "tx_all");
    cycles(5);
    chk("tx_count", tx_acc - base, 3);
    chk("tx_burst", blog[lb], 203);
    cycles(30);
    chk("siwu_after_tx3", pulses, 1);

    // SIWU: two words then idle -> exactly one pulse
    p0 = pulses; base = tx_acc;
    load_tx(8'h5A); load_tx(8'hA5);
    wait_acc(1, base + 2, "tx_siwu");
    cycles(40);
    chk("siwu_once", pulses - p0, 1);

    // RX FIFO full for 3 cycles mid-burst
    base = rx_acc; lb = blog_n; wf_stall = 0;
    for (int i = 0; i < 4; i++) offer_rx(8'hD0 + 8'(i));
    wait_acc(0, base + 2, "rx_wf_first");
    rx_wfull = 1'b1;
    cycles(3);
    rx_wfull = 1'b0;
    wait_acc(0, base + 4, "rx_wf_all");
    cycles(4);
    chk("wf_stall_cycles", wf_stall, 3);
    chk("rx_wf_count", rx_acc - base, 4);
    chk("rx_wf_burst", blog[lb], 104);

    // Reset in the middle of an RX burst; remaining words still arrive in order
    base = rx_acc;
    for (int i = 0; i < 6; i++) offer_rx(8'hC0 + 8'(i));
    wait_acc(0, base + 1, "rx_rst_first");
    do_reset();
    wait_acc(0, base + 6, "rx_rst_all");
    cycles(4);
    chk("rx_rst_count", rx_acc - base, 6);

    // Fairness with cap 4 and 10 words each way, starting from reset
    do_reset();
    cycles(1);
    base = rx_acc; p0 = tx_acc; lb = blog_n;
    for (int i = 0; i < 10; i++) begin
      offer_rx(8'h40 + 8'(i));
      load_tx(8'h80 + 8'(i));
    end
    wait_acc(0, base + 10, "fair_rx");
    wait_acc(1, p0 + 10, "fair_tx");
    cycles(30);
    exp4[0] = 104; exp4[1] = 204; exp4[2] = 104;
    exp4[3] = 204; exp4[4] = 102; exp4[5] = 202;
    for (int i = 0; i < 6; i++) chk($sformatf("fair_grant%0d", i), blog[lb + i], exp4[i]);
    chk("fair_grant_total", blog_n - lb, 6);

    chk("rx_queue_drained", exp_rx.size(), 0);
    chk("tx_queue_drained", exp_tx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
